// File: rtl/axis_fifo_pkg.sv
// ============================================================================
// Module      : axis_fifo_pkg
// Description : Shared types and helpers for the single-clock AXI-Stream FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_fifo_pkg;

  // Control state of the FIFO, tracking the fill level in coarse terms
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } FifoState_t;

  // Pointer width: address bits plus one wrap bit
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : axis_fifo_pkg

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// Module      : fifo_ram
// Description : Single-clock storage array, one synchronous write port and
//               one asynchronous read port. No control logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ram
  import axis_fifo_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int DEPTH    = 16
) (
  input  logic                            clk,
  input  logic                            we_i,
  input  logic [ptr_width(DEPTH)-2:0]     waddr_i,
  input  logic [BITWIDTH-1:0]             wdata_i,
  input  logic [ptr_width(DEPTH)-2:0]     raddr_i,
  output logic [BITWIDTH-1:0]             rdata_o
);

  logic [BITWIDTH-1:0] mem_q [DEPTH];

  // Store one beat per cycle when the write enable is asserted
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_ram

`default_nettype wire

// File: rtl/axis_sync_fifo.sv
// ============================================================================
// Module      : axis_sync_fifo
// Description : Single-clock AXI-Stream FIFO with first-word-fall-through
//               output, fill level and synchronous flush.
//               Optional macro AXIS_SYNC_FIFO_ALMOST_EN enables registered
//               almost_full / almost_empty flags; otherwise both tie to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_sync_fifo
  import axis_fifo_pkg::*;
#(
  parameter int BITWIDTH      = 8,
  parameter int DEPTH         = 16,
  parameter int ALMOST_THRESH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  // write side (slave)
  input  logic [BITWIDTH-1:0]     wr_data_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  output logic                    wr_ok_o,
  // read side (master)
  output logic [BITWIDTH-1:0]     rd_data_o,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  output logic                    rd_ok_o,
  // status
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       count_q,  count_d;
  FifoState_t          state_q,  state_d;

  logic                empty;
  logic                full;
  logic                wr_ok;
  logic                rd_ok;
  logic                ram_we;
  logic [BITWIDTH-1:0] ram_rdata;

  // Flags come purely from registered pointers, so wr_ready never depends
  // combinationally on rd_ready.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign wr_ready_o = ~full;
  assign rd_valid_o = ~empty;
  assign wr_ok      = wr_valid_i & wr_ready_o;
  assign rd_ok      = rd_valid_o & rd_ready_i;
  assign wr_ok_o    = wr_ok;
  assign rd_ok_o    = rd_ok;

  // A flushed or reset cycle must not disturb storage with a stale write
  assign ram_we    = wr_ok & ~flush_i & ~rst;
  assign rd_data_o = empty ? '0 : ram_rdata;
  assign count_o   = count_q;

  fifo_ram #(
    .BITWIDTH (BITWIDTH),
    .DEPTH    (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // Next pointers and fill level; flush discards any same-cycle handshake
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control FSM next state, following the fill level transitions
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:  if (wr_ok) state_d = ACTIVE;
        ACTIVE: begin
          if (wr_ok && !rd_ok && (count_q == PW'(DEPTH - 1))) begin
            state_d = FULL;
          end else if (rd_ok && !wr_ok && (count_q == PTR_ONE)) begin
            state_d = EMPTY;
          end
        end
        FULL:   if (rd_ok) state_d = ACTIVE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Pointer, count and state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

`ifdef AXIS_SYNC_FIFO_ALMOST_EN
  logic almost_full_q;
  logic almost_empty_q;

  // Threshold flags registered from next count so they line up with count_o
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_d >= PW'(DEPTH - ALMOST_THRESH));
      almost_empty_q <= (count_d <= PW'(ALMOST_THRESH));
    end
  end

  assign almost_full_o  = almost_full_q;
  assign almost_empty_o = almost_empty_q;
`else
  assign almost_full_o  = 1'b0;
  assign almost_empty_o = 1'b0;
`endif

endmodule : axis_sync_fifo

`default_nettype wire
